// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-write arbiter slice.
package reg_write_arbiter_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_NUM_REGS = 4;
  localparam int ADDR_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } state_t;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side handshake plus the shared write bus to the register bank.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       wr_load;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;

  // Requesters and the register bank.
  modport master (
    output req, addr, data,
    input  gnt, wr_load, wr_data, busy
  );

  // The arbiter itself.
  modport slave (
    input  req, addr, data,
    output gnt, wr_load, wr_data, busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping.
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // First set request at offsets 1..NUM_REQ from ptr wins; ptr itself is last.
  always_comb begin
    // NOTE: defaults come first so every path drives grant/valid and no latch is inferred.
    grant = '0;
    valid = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
          grant[i] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter funnelling requester writes onto one register-bank bus.
// IDLE picks a winner, LOAD pulses wr_load for one cycle, ACK pulses gnt.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input logic                clk,
  input logic                clr,
  reg_write_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Turn the one-hot winner into an index and steer out its addr/data slices.
  always_comb begin
    pick_idx  = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx  = IDX_W'(i);
        pick_addr = bus.addr[i*ADDR_W +: ADDR_W];
        pick_data = bus.data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Control FSM with registered outputs; the winner's request is captured on
  // IDLE->LOAD, so input churn during LOAD/ACK cannot disturb the write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values.
    if (clr) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      winner      <= '0;
      bus.gnt     <= '0;
      bus.wr_load <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= LOAD;
            winner      <= pick_idx;
            bus.wr_load <= NUM_REGS'(1) << pick_addr;
            bus.wr_data <= pick_data;
            bus.busy    <= 1'b1;
          end
        end
        LOAD: begin
          state       <= ACK;
          bus.wr_load <= '0;
          bus.gnt     <= NUM_REQ'(1) << winner;
          ptr         <= winner;
        end
        ACK: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.gnt     <= '0;
          bus.wr_load <= '0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
